// File: rtl/joy_scan_pkg.sv
// Shared constants for the joystick shift-chain scanner.
// Holds the frame slot numbering, the capture width, the idle
// (nothing pressed) word, and the capture-to-word bit map.
// In each map, entry b is the capture bit that drives word bit b.
package joy_scan_pkg;

    localparam int JOY_BITS = 24;
    localparam int JOY_WORD = 12;

    localparam logic [4:0] LOAD_SLOT         = 5'd0;
    localparam logic [4:0] FIRST_SAMPLE_SLOT = 5'd2;
    localparam logic [4:0] LAST_SLOT         = 5'd25;

    localparam logic [JOY_WORD-1:0] JOY_IDLE = 12'hFFF;

    // joystick1: k0..7 -> bits 8,6,5,4,3,2,1,0 ; k20..23 -> bits 10,11,9,7
    localparam int J1_SRC [JOY_WORD] = '{7, 6, 5, 4, 3, 2, 1, 23, 0, 22, 20, 21};
    // joystick2: k8..15 -> bits 8,6,5,4,3,2,1,0 ; k16..19 -> bits 10,11,9,7
    localparam int J2_SRC [JOY_WORD] = '{15, 14, 13, 12, 11, 10, 9, 19, 8, 18, 16, 17};

endpackage

// File: rtl/joy_scan_if.sv
// Board-side chain pins plus the decoded joystick words.
//   joy_clk, joy_load : shift clock / active-low load strobe to the chain
//   joy_data          : serial data from the chain
//   joystick1/2       : active-low 12-bit player words
//   frame_done        : one-cycle pulse when the words update
// master = the scanner, slave = the chain/core side.
interface joy_scan_if;
    logic        joy_clk;
    logic        joy_load;
    logic        joy_data;
    logic [11:0] joystick1;
    logic [11:0] joystick2;
    logic        frame_done;

    modport master (
        output joy_clk, joy_load, joystick1, joystick2, frame_done,
        input  joy_data
    );

    modport slave (
        input  joy_clk, joy_load, joystick1, joystick2, frame_done,
        output joy_data
    );
endinterface

// File: rtl/joy_clk_gen.sv
// Free-running square shift clock built from clock enables.
//   clk, reset : system clock, asynchronous active-high reset
//   joy_clk    : registered square wave, period 2*CLK_DIV clk cycles
//   rise       : high on the clk cycle whose edge takes joy_clk 0->1
module joy_clk_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    output logic joy_clk,
    output logic rise
);

    logic [7:0] div_cnt_reg;
    logic       joy_clk_reg;
    logic       wrap;

    assign wrap = (div_cnt_reg == 8'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_reg <= 8'd0;
            joy_clk_reg <= 1'b0;
        end else if (wrap) begin
            div_cnt_reg <= 8'd0;
            joy_clk_reg <= ~joy_clk_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + 8'd1;
        end
    end

    // Combinational so the slot logic acts on the same edge that raises joy_clk.
    assign rise    = wrap & ~joy_clk_reg;
    assign joy_clk = joy_clk_reg;

endmodule

// File: rtl/joy_scan_ctrl.sv
// Joystick shift-chain sequencer.
// Each frame: slot 0 loads the chain (joy_load low), slot 1 settles,
// slots 2..25 each sample one bit on the joy_clk rise that ends them.
// After the last sample the two active-low words load together from
// the capture register and frame_done pulses.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : chain pins and joystick words (joy_scan_if.master)
// Optional build macro JOY_DEBOUNCE_EN: words only update when two
// consecutive frames captured identical data.
module joy_scan_ctrl
    import joy_scan_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int NUM_SLOTS = 26
) (
    input  logic        clk,
    input  logic        reset,
    joy_scan_if.master  bus
);

    localparam logic [4:0] SLOT_LAST = 5'(NUM_SLOTS - 1);

    logic                rise;
    logic                joy_clk;
    logic [4:0]          slot_reg;
    logic [4:0]          slot_next;
    logic [JOY_BITS-1:0] capture_reg;
    logic                frame_end_reg;
    logic                joy_load_reg;
    logic [11:0]         j1_reg;
    logic [11:0]         j2_reg;
    logic                frame_done_reg;
    logic [11:0]         j1_map;
    logic [11:0]         j2_map;
    logic                update_ok;

    joy_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk     (clk),
        .reset   (reset),
        .joy_clk (joy_clk),
        .rise    (rise)
    );

    always_comb begin
        slot_next = slot_reg;
        if (rise) begin
            slot_next = (slot_reg == SLOT_LAST) ? LOAD_SLOT : slot_reg + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_reg      <= LOAD_SLOT;
            capture_reg   <= '1;
            frame_end_reg <= 1'b0;
            joy_load_reg  <= 1'b1;
        end else begin
            slot_reg      <= slot_next;
            // Follows slot_next so joy_load is low for exactly the slot-0 cycles.
            joy_load_reg  <= (slot_next != LOAD_SLOT);
            frame_end_reg <= rise && (slot_reg == SLOT_LAST);
            if (rise && slot_reg >= FIRST_SAMPLE_SLOT) begin
                capture_reg[slot_reg - FIRST_SAMPLE_SLOT] <= bus.joy_data;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < JOY_WORD; gi++) begin : g_map
            assign j1_map[gi] = capture_reg[J1_SRC[gi]];
            assign j2_map[gi] = capture_reg[J2_SRC[gi]];
        end
    endgenerate

`ifdef JOY_DEBOUNCE_EN
    logic [JOY_BITS-1:0] prev_capture_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_capture_reg <= '1;
        end else if (frame_end_reg) begin
            prev_capture_reg <= capture_reg;
        end
    end

    assign update_ok = frame_end_reg && (capture_reg == prev_capture_reg);
`else
    assign update_ok = frame_end_reg;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            j1_reg         <= JOY_IDLE;
            j2_reg         <= JOY_IDLE;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= update_ok;
            if (update_ok) begin
                j1_reg <= j1_map;
                j2_reg <= j2_map;
            end
        end
    end

    assign bus.joy_clk    = joy_clk;
    assign bus.joy_load   = joy_load_reg;
    assign bus.joystick1  = j1_reg;
    assign bus.joystick2  = j2_reg;
    assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_joy_scan_ctrl.sv
// Bench for joy_scan_ctrl at CLK_DIV=2. A chain model loads an image on
// joy_load, drives one bit per joy_clk falling edge, and pushes the frame
// it actually sent to a scoreboard; the monitor pops on each frame_done.
module tb_joy_scan_ctrl;

    localparam int CLK_DIV = 2;
    localparam int FRAME   = 26 * 2 * CLK_DIV;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   glitch_cnt = 0;

    joy_scan_if bus ();

    joy_scan_ctrl #(.CLK_DIV(CLK_DIV), .NUM_SLOTS(26)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Word layout written out from the bit map table (bit 11 down to bit 0).
    function automatic logic [11:0] exp_j1(input logic [23:0] s);
        return {s[21], s[20], s[22], s[0], s[23], s[1], s[2], s[3], s[4], s[5], s[6], s[7]};
    endfunction

    function automatic logic [11:0] exp_j2(input logic [23:0] s);
        return {s[17], s[16], s[18], s[8], s[19], s[9], s[10], s[11], s[12], s[13], s[14], s[15]};
    endfunction

    // ---------------- chain model + scoreboard push ----------------
    logic [23:0] img       = '1;
    logic [23:0] sent      = '1;
    logic [23:0] prev_sent = '1;
    int          pos       = -1;
    logic [23:0] exp_q [$];

    initial bus.joy_data = 1'b1;

    always @(negedge bus.joy_clk or posedge reset) begin
        if (reset) begin
            pos = -1;
            prev_sent = '1;
            bus.joy_data = 1'b1;
            exp_q.delete();
        end else begin
            if (!bus.joy_load) pos = -1;
            else               pos = pos + 1;
            if (pos >= 1 && pos <= 24) begin
                sent[pos-1] = img[pos-1];
                bus.joy_data = img[pos-1];
            end else begin
                bus.joy_data = 1'b1;
            end
            if (pos == 24) begin
`ifdef JOY_DEBOUNCE_EN
                if (sent == prev_sent) exp_q.push_back(sent);
                prev_sent = sent;
`else
                exp_q.push_back(sent);
`endif
            end
        end
    end

    // ---------------- monitor / scoreboard pop ----------------
    logic [23:0] last_w = '1;
    logic [23:0] e;

    always @(negedge clk) begin
        if (reset) begin
            last_w = '1;
        end else begin
            if (bus.frame_done) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_frame_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("sb_j1", {20'd0, bus.joystick1}, {20'd0, exp_j1(e)});
                    check_val("sb_j2", {20'd0, bus.joystick2}, {20'd0, exp_j2(e)});
                end
            end else if ({bus.joystick1, bus.joystick2} != last_w) begin
                glitch_cnt++;
            end
            last_w = {bus.joystick1, bus.joystick2};
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!bus.frame_done && n < 3 * FRAME);
        check_val({tag, "_seen"}, {31'd0, bus.frame_done}, 32'd1);
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (pos != p && n < 2 * FRAME) begin
            step();
            n++;
        end
        check_val("pos_reached", pos, p);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_joy_load"},   {31'd0, bus.joy_load},   32'd1);
        check_val({tag, "_joy_clk"},    {31'd0, bus.joy_clk},    32'd0);
        check_val({tag, "_joystick1"},  {20'd0, bus.joystick1},  32'hFFF);
        check_val({tag, "_joystick2"},  {20'd0, bus.joystick2},  32'hFFF);
        check_val({tag, "_frame_done"}, {31'd0, bus.frame_done}, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   rises [$];
        int   falls [$];
        int   lrise [$];
        logic pc, pl;
        int   n;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");

        @(negedge clk);
        reset = 1'b0;

        // Timing of joy_clk and joy_load. The first load pulse after reset is
        // cut short (joy_clk starts low, so its first rise comes after half a
        // period), so the steady-state load pulse is measured from the second.
        pc = bus.joy_clk;
        pl = bus.joy_load;
        for (int i = 1; i <= 320; i++) begin
            step();
            if (!pc && bus.joy_clk)  rises.push_back(i);
            if (pl && !bus.joy_load) falls.push_back(i);
            if (!pl && bus.joy_load) lrise.push_back(i);
            pc = bus.joy_clk;
            pl = bus.joy_load;
        end
        check_val("joy_clk_period", (rises.size() >= 2) ? rises[1] - rises[0] : 0, 2 * CLK_DIV);
        check_val("joy_load_low",   (falls.size() >= 3 && lrise.size() >= 2) ? lrise[1] - falls[1] : 0, 2 * CLK_DIV);
        check_val("joy_load_period", (falls.size() >= 3) ? falls[2] - falls[1] : 0, FRAME);

        // Only k0 low.
        wait_frame("sync_a");
        img = 24'hFFFFFE;
        wait_frame("k0");
        check_val("k0_j1", {20'd0, bus.joystick1}, 32'hEFF);
        check_val("k0_j2", {20'd0, bus.joystick2}, 32'hFFF);
        step();
        check_val("frame_done_width", {31'd0, bus.frame_done}, 32'd0);

        // k17 (P2 reset) and k22 (P1 coin) low.
        img = ~((24'd1 << 17) | (24'd1 << 22));
        wait_frame("k17_k22");
        check_val("k17_k22_j1", {20'd0, bus.joystick1}, 32'hDFF);
        check_val("k17_k22_j2", {20'd0, bus.joystick2}, 32'h7FF);

        // Change the chain at slot 10: bits k0..k7 already went out from the
        // old image, k8..k23 come from the new one.
        img = 24'hFFFFFE;
        wait_frame("pre_mid");
        wait_frame("pre_mid2");
        wait_pos(8);
        img = ~((24'd1 << 17) | (24'd1 << 22));
        wait_frame("mid");
`ifndef JOY_DEBOUNCE_EN
        check_val("mid_j1", {20'd0, bus.joystick1}, 32'hCFF);
        check_val("mid_j2", {20'd0, bus.joystick2}, 32'h7FF);
`endif

`ifdef JOY_DEBOUNCE_EN
        // One-frame glitch on k3 must never show; a two-frame press must.
        img = '1;
        wait_frame("db_idle");
        wait_frame("db_idle2");
        wait_pos(0);
        img = ~(24'd1 << 3);
        wait_pos(24);
        wait_pos(0);
        img = '1;
        repeat (3 * FRAME) step();
        check_val("db_glitch_j1", {20'd0, bus.joystick1}, 32'hFFF);
        img = ~(24'd1 << 3);
        wait_frame("db_press");
        check_val("db_press_j1", {20'd0, bus.joystick1}, 32'hFEF);  // k3 drives bit 4
`endif

        // Reset in slot 14 with non-idle words showing.
        img = ~((24'd1 << 17) | (24'd1 << 22));
        wait_frame("pre_rst");
        wait_frame("pre_rst2");
        wait_pos(12);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        img = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        // Slot 0 after reset lasts half a period, so the first update lands
        // CLK_DIV*(2*26-1) cycles after release plus the output register cycle.
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.frame_done && n < 3 * FRAME);
        check_val("first_frame_done_cycles", n, CLK_DIV * (2 * 26 - 1) + 1);

        wait_frame("final");
        step();
        check_val("no_partial_update", glitch_cnt, 0);
        check_val("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
